// File: rtl/imem_pipe.sv
// Pipelined instruction memory with valid/ready fetch and a program-load port.
// Define IMEM_BOOT_ROM_EN to hardwire word 0 to a boot instruction.
module imem_pipe #(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 1,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_data,
   output logic          rsp_fault,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data,
   output logic          busy
);

   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
   localparam logic [31:0] BOOT_WORD = 32'h2000_0113;

   logic [31:0] mem [MEM_WORDS];

   logic [LATENCY-1:0]       v_q, v_d;
   logic [LATENCY-1:0]       f_q, f_d;
   logic [LATENCY-1:0][31:0] d_q, d_d;

   logic [AW-1:0] idx;
   logic          fault;
   logic          stall;
   logic          acc;
   logic          ld_we;
   logic [31:0]   rd_word;

   always_comb begin
      idx       = req_addr[AW+1:2];
      fault     = (req_addr[1:0] != 2'b00) ||
                  (req_addr[31:AW+2] != '0);
      stall     = v_q[LATENCY-1] && !rsp_ready;
      req_ready = !reset && !ld_en && !stall;
      acc       = req_valid && req_ready;
`ifdef IMEM_BOOT_ROM_EN
      ld_we   = ld_en && (ld_addr != '0);
      if (fault)
         rd_word = NOP_WORD;
      else if (idx == '0)
         rd_word = BOOT_WORD;
      else
         rd_word = mem[idx];
`else
      ld_we   = ld_en;
      rd_word = fault ? NOP_WORD : mem[idx];
`endif
   end

   // Data is captured at acceptance, so later loads never alter in-flight words.
   always_comb begin
      v_d = v_q;
      f_d = f_q;
      d_d = d_q;
      if (reset) begin
         v_d = '0;
         f_d = '0;
         d_d = '0;
      end else if (!stall) begin
         v_d[0] = acc;
         f_d[0] = acc && fault;
         d_d[0] = acc ? rd_word : '0;
         for (int i = 1; i < LATENCY; i++) begin
            v_d[i] = v_q[i-1];
            f_d[i] = f_q[i-1];
            d_d[i] = d_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      v_q <= v_d;
      f_q <= f_d;
      d_q <= d_d;
   end

   always_ff @(posedge clk) begin
      if (ld_we)
         mem[ld_addr] <= ld_data;
   end

   assign rsp_valid = v_q[LATENCY-1];
   assign rsp_fault = f_q[LATENCY-1];
   assign rsp_data  = d_q[LATENCY-1];
   assign busy      = |v_q;

endmodule

// File: tb/tb_imem_pipe.sv
// Directed bench for imem_pipe: instance 0 has LATENCY=1, instance 1 LATENCY=3.
// Honours IMEM_BOOT_ROM_EN in its expected values for word 0.
module tb_imem_pipe;

   logic        clk;
   logic        reset;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [31:0] req_addr  [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_data  [2];
   logic        rsp_fault [2];
   logic        ld_en     [2];
   logic [9:0]  ld_addr   [2];
   logic [31:0] ld_data   [2];
   logic        busy      [2];

   int n_chk;
   int n_fail;

   imem_pipe #(.MEM_WORDS(1024), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_data(rsp_data[0]), .rsp_fault(rsp_fault[0]),
      .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]),
      .busy(busy[0])
   );

   imem_pipe #(.MEM_WORDS(1024), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_data(rsp_data[1]), .rsp_fault(rsp_fault[1]),
      .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]),
      .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int k, input logic [9:0] a,
                       input logic [31:0] d);
      ld_en[k]   = 1'b1;
      ld_addr[k] = a;
      ld_data[k] = d;
      tick();
      ld_en[k]   = 1'b0;
   endtask

   function automatic logic [31:0] word0(input logic [31:0] stored);
`ifdef IMEM_BOOT_ROM_EN
      return 32'h2000_0113;
`else
      return stored;
`endif
   endfunction

   initial begin
      n_chk  = 0;
      n_fail = 0;
      reset  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0;
         req_addr[k]  = '0;
         rsp_ready[k] = 1'b1;
         ld_en[k]     = 1'b0;
         ld_addr[k]   = '0;
         ld_data[k]   = '0;
      end
      tick();
      tick();

      // reset state
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
         chk($sformatf("rst_data%0d", k), rsp_data[k], 32'd0);
         chk($sformatf("rst_fault%0d", k), 32'(rsp_fault[k]), 32'd0);
         chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
         chk($sformatf("rst_rdy%0d", k), 32'(req_ready[k]), 32'd0);
      end
      reset = 1'b0;
      #1;
      chk("post_rst_rdy", 32'(req_ready[0]), 32'd1);

      // single fetch, LATENCY=1
      ld_en[0]   = 1'b1;
      ld_addr[0] = 10'd5;
      ld_data[0] = 32'hDEAD_BEEF;
      #1;
      chk("ld_blocks_rdy", 32'(req_ready[0]), 32'd0);
      tick();
      ld_en[0]     = 1'b0;
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h14;
      #1;
      chk("t1_pre_valid", 32'(rsp_valid[0]), 32'd0);
      tick();
      req_valid[0] = 1'b0;
      chk("t1_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t1_data", rsp_data[0], 32'hDEAD_BEEF);
      chk("t1_fault", 32'(rsp_fault[0]), 32'd0);
      chk("t1_busy", 32'(busy[0]), 32'd1);
      tick();
      chk("t1_drain", 32'(rsp_valid[0]), 32'd0);
      chk("t1_idle", 32'(busy[0]), 32'd0);

      // faults: misaligned then out of range, back to back
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h16;
      tick();
      req_addr[0]  = 32'h1000;
      chk("mis_valid", 32'(rsp_valid[0]), 32'd1);
      chk("mis_fault", 32'(rsp_fault[0]), 32'd1);
      chk("mis_data", rsp_data[0], 32'h13);
      tick();
      req_valid[0] = 1'b0;
      chk("oor_valid", 32'(rsp_valid[0]), 32'd1);
      chk("oor_fault", 32'(rsp_fault[0]), 32'd1);
      chk("oor_data", rsp_data[0], 32'h13);
      tick();
      chk("oor_drain", 32'(rsp_valid[0]), 32'd0);

      // backpressure stall on LATENCY=1
      for (int i = 10; i < 13; i++)
         load(0, 10'(i), 32'hA000_0000 + 32'(i));
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'd40;
      tick();
      chk("st_first", rsp_data[0], 32'hA000_000A);
      rsp_ready[0] = 1'b0;
      req_addr[0]  = 32'd44;
      #1;
      chk("st_rdy_drop", 32'(req_ready[0]), 32'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("st_hold_v%0d", c), 32'(rsp_valid[0]), 32'd1);
         chk($sformatf("st_hold_d%0d", c), rsp_data[0], 32'hA000_000A);
         chk($sformatf("st_hold_r%0d", c), 32'(req_ready[0]), 32'd0);
      end
      rsp_ready[0] = 1'b1;
      #1;
      chk("st_release_rdy", 32'(req_ready[0]), 32'd1);
      tick();
      req_addr[0] = 32'd48;
      chk("st_next", rsp_data[0], 32'hA000_000B);
      tick();
      req_valid[0] = 1'b0;
      chk("st_last", rsp_data[0], 32'hA000_000C);
      tick();
      chk("st_drain", 32'(rsp_valid[0]), 32'd0);

      // boot ROM word 0
      load(0, 10'd0, 32'hFFFF_FFFF);
      req_valid[0] = 1'b1;
      req_addr[0]  = 32'h0;
      tick();
      req_valid[0] = 1'b0;
      chk("boot_word0", rsp_data[0], word0(32'hFFFF_FFFF));
      tick();

      // LATENCY=3 back-to-back burst
      for (int i = 0; i < 8; i++)
         load(1, 10'(i), 32'h1111_1111 * 32'(i));
      req_valid[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr[1] = 32'(i * 4);
         #1;
         chk($sformatf("b_rdy%0d", i), 32'(req_ready[1]), 32'd1);
         tick();
         if (i < 2) begin
            chk($sformatf("b_early%0d", i), 32'(rsp_valid[1]), 32'd0);
         end else begin
            chk($sformatf("b_v%0d", i - 2), 32'(rsp_valid[1]), 32'd1);
            chk($sformatf("b_d%0d", i - 2), rsp_data[1],
                (i == 2) ? word0(32'h0) : 32'h1111_1111 * 32'(i - 2));
         end
      end
      req_valid[1] = 1'b0;
      for (int i = 6; i < 8; i++) begin
         tick();
         chk($sformatf("b_v%0d", i), 32'(rsp_valid[1]), 32'd1);
         chk($sformatf("b_d%0d", i), rsp_data[1], 32'h1111_1111 * 32'(i));
      end
      tick();
      chk("b_drain", 32'(rsp_valid[1]), 32'd0);

      // load after accept, then reset with a fetch in flight (LATENCY=3)
      load(1, 10'd2, 32'h1);
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h8;
      tick();
      req_valid[1] = 1'b0;
      ld_en[1]     = 1'b1;
      ld_addr[1]   = 10'd2;
      ld_data[1]   = 32'h2;
      tick();
      ld_en[1]     = 1'b0;
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h4;
      tick();
      req_valid[1] = 1'b0;
      chk("lr_old_v", 32'(rsp_valid[1]), 32'd1);
      chk("lr_old_d", rsp_data[1], 32'h1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("lr_rst_v", 32'(rsp_valid[1]), 32'd0);
      chk("lr_rst_busy", 32'(busy[1]), 32'd0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("lr_none%0d", c), 32'(rsp_valid[1]), 32'd0);
      end
      req_valid[1] = 1'b1;
      req_addr[1]  = 32'h8;
      tick();
      req_valid[1] = 1'b0;
      tick();
      chk("lr_pend", 32'(rsp_valid[1]), 32'd0);
      tick();
      chk("lr_new_v", 32'(rsp_valid[1]), 32'd1);
      chk("lr_new_d", rsp_data[1], 32'h2);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_pipe.md
Name: imem_pipe

Overview:
- Parametrised, synchronous-read successor to the single-cycle instruction memory.
- Word-organised instruction store with a valid/ready fetch request/response interface.
- Configurable read latency, with full-pipeline stall on response backpressure.
- Fault reporting for misaligned or out-of-range fetches, plus a word-write program-load port that replaces file-based preload.
- Sits between the fetch stage of the pipelined core and the program loader/testbench.

Parameters:
- MEM_WORDS, 1024, number of 32-bit instruction words; power of two, 16..65536.
- LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
- AW, $clog2(MEM_WORDS), width of the word index (derived; do not override).

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-high.
- req_valid, in, 1, fetch request valid.
- req_ready, out, 1, fetch request can be accepted this cycle.
- req_addr, in, 32, byte address of the instruction.
- rsp_valid, out, 1, response word valid.
- rsp_ready, in, 1, consumer accepts the response.
- rsp_data, out, 32, instruction word.
- rsp_fault, out, 1, the request was misaligned or out of range.
- ld_en, in, 1, program-load write strobe.
- ld_addr, in, AW, word index for the load write.
- ld_data, in, 32, word to store.
- busy, out, 1, at least one fetch is in flight.

Behaviour:
- Clocking: single clock domain (clk). Reset is synchronous and active-high.
- Reset:
  - Flushes every pipeline stage.
  - rsp_valid=0, rsp_data=0, rsp_fault=0, busy=0.
  - req_ready=0 during the reset cycle.
  - Storage contents are NOT cleared.
  - Reset mid-flight drops all outstanding fetches; no response is ever produced for them.
- Storage: MEM_WORDS x 32 bits. The word index is req_addr[AW+1:2]. Words are stored and returned as written; no byte swapping.
- Pipeline: LATENCY stage registers, each holding {valid, data, fault}.
  - Stage 1 captures the array read at the acceptance edge.
  - The last stage drives rsp_*.
- Accept: req_valid && req_ready at a rising edge.
  - req_ready = !reset && !ld_en && !(rsp_valid && !rsp_ready).
- Stall: while rsp_valid && !rsp_ready, every stage holds and rsp_data/rsp_fault stay stable. No bubbles are collapsed; the whole pipe freezes.
- Latency: absent stall, an accept at edge N gives rsp_valid=1 after edge N+LATENCY-1, i.e. visible in the cycle following that edge.
  - For LATENCY=1: registered output, valid the cycle after the accept.
- Throughput: one accept per cycle when rsp_ready is held high. Back-to-back responses are in request order.
- Fault conditions: req_addr[1:0]!=0, or req_addr[31:AW+2]!=0.
  - The response still completes: rsp_fault=1, rsp_data=32'h00000013 (NOP).
  - The array is not indexed.
- Load port:
  - ld_en writes ld_data into word ld_addr at the edge.
  - ld_en has priority: req_ready is forced 0 while ld_en=1.
  - In-flight fetches continue to drain. They return data captured at their acceptance edge, so a later load does not alter them.
  - A load during the reset cycle is performed.
- busy: OR of all stage valid bits.
- Simultaneous accept and response handshake in the same cycle is legal and sustains full rate.

Optional Feature:
- Macro: IMEM_BOOT_ROM_EN.
- Defined:
  - Word 0 is hardwired to 32'h20000113 (addi sp, x0, 0x200).
  - Fetches of byte address 0 return that word.
  - ld_en writes with ld_addr=0 are ignored.
  - User programs are loaded from word 1 (byte 0x4).
- Undefined: word 0 is ordinary storage, writable through the load port.

Test Plan:
- Load word 5 = 32'hDEADBEEF, then fetch 0x14 with rsp_ready=1 and LATENCY=1 -> rsp_valid exactly one cycle after accept, rsp_data=32'hDEADBEEF, rsp_fault=0.
- LATENCY=3: load words 0..7 = index*0x11111111 (boot ROM off); fetch 0x0,0x4,...,0x1C back-to-back -> 8 in-order responses starting 3 cycles after the first accept, one per cycle, req_ready held 1.
- Fetch 0x16 (misaligned), then 0x1000 with MEM_WORDS=1024 (out of range) -> both responses have rsp_fault=1 and rsp_data=32'h00000013.
- Stream fetches and drop rsp_ready for 4 cycles mid-stream -> req_ready=0 and rsp_data frozen during the stall; no response lost or duplicated after release.
- Accept a fetch of word 2 (old value 32'h1), assert ld_en to word 2 = 32'h2 the next cycle, and assert reset while a second fetch is in flight -> first response returns 32'h1; no response for the flushed fetch; a post-reset fetch of word 2 returns 32'h2.
- With IMEM_BOOT_ROM_EN: load word 0 = 32'hFFFFFFFF, then fetch 0x0 -> 32'h20000113. Without the macro, the same sequence returns 32'hFFFFFFFF.
